// File: rtl/machine_timer.sv
`default_nettype none
// ============================================================================
// Module   : machine_timer
// Summary  : Bus-slave machine timer: 64-bit mtime with prescaler, 64-bit
//            mtimecmp and a level interrupt while mtime >= mtimecmp.
//            Optional macro MACHINE_TIMER_SNAPSHOT_EN adds a coherent
//            lo-then-hi read shadow for mtime_hi.
// Revision : 1.0 - initial release
// ============================================================================
module machine_timer #(
   parameter logic [31:0] BASE_ADDR  = 32'h4000_0000,
   parameter int          PRESCALE_W = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] bus_address,
   input  logic [31:0] bus_write_data,
   input  logic [3:0]  bus_byte_enable,
   input  logic        bus_write_enable,
   input  logic        bus_read_enable,
   output logic [31:0] bus_read_data,
   output logic        bus_busy,
   output logic        timer_interrupt_request
);

   localparam logic [2:0] OFF_MTIME_LO = 3'd0;
   localparam logic [2:0] OFF_MTIME_HI = 3'd1;
   localparam logic [2:0] OFF_CMP_LO   = 3'd2;
   localparam logic [2:0] OFF_CMP_HI   = 3'd3;
   localparam logic [2:0] OFF_CTRL     = 3'd4;

   logic                  sel;
   logic                  wr_hit;
   logic                  rd_hit;
   logic [2:0]            offset;
   logic [31:0]           wmask;
   logic [31:0]           ctrl_word;
   logic                  tick;

   logic [63:0]           mtime_q, mtime_d;
   logic [63:0]           mtimecmp_q, mtimecmp_d;
   logic                  enable_q, enable_d;
   logic [PRESCALE_W-1:0] div_q, div_d;
   logic [PRESCALE_W-1:0] pcnt_q, pcnt_d;
   logic                  irq_q, irq_d;
`ifdef MACHINE_TIMER_SNAPSHOT_EN
   logic [31:0]           shadow_q, shadow_d;
`endif

   logic unused_addr_lsbs;
   assign unused_addr_lsbs = &{1'b0, bus_address[1:0]};

   function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                                input logic [31:0] new_v,
                                                input logic [31:0] mask);
      return (old_v & ~mask) | (new_v & mask);
   endfunction

   always_comb begin
      sel       = (bus_address[31:5] == BASE_ADDR[31:5]);
      offset    = bus_address[4:2];
      wr_hit    = sel & bus_write_enable;
      rd_hit    = sel & bus_read_enable;
      wmask     = {{8{bus_byte_enable[3]}}, {8{bus_byte_enable[2]}},
                   {8{bus_byte_enable[1]}}, {8{bus_byte_enable[0]}}};
      ctrl_word = (32'(div_q) << 16) | {31'd0, enable_q};
      tick      = enable_q & (pcnt_q == div_q);
   end

   always_comb begin
      mtime_d    = mtime_q;
      mtimecmp_d = mtimecmp_q;
      enable_d   = enable_q;
      div_d      = div_q;
      pcnt_d     = pcnt_q;

      if (enable_q) begin
         pcnt_d = tick ? '0 : pcnt_q + 1'b1;
      end
      if (tick) begin
         mtime_d = mtime_q + 64'd1;
      end

      // A write to either mtime half replaces the increment and restarts the prescaler.
      if (wr_hit) begin
         case (offset)
            OFF_MTIME_LO: begin
               mtime_d = {mtime_q[63:32], merge_bytes(mtime_q[31:0], bus_write_data, wmask)};
               pcnt_d  = '0;
            end
            OFF_MTIME_HI: begin
               mtime_d = {merge_bytes(mtime_q[63:32], bus_write_data, wmask), mtime_q[31:0]};
               pcnt_d  = '0;
            end
            OFF_CMP_LO: begin
               mtimecmp_d[31:0] = merge_bytes(mtimecmp_q[31:0], bus_write_data, wmask);
            end
            OFF_CMP_HI: begin
               mtimecmp_d[63:32] = merge_bytes(mtimecmp_q[63:32], bus_write_data, wmask);
            end
            OFF_CTRL: begin
               if (bus_byte_enable[0]) begin
                  enable_d = bus_write_data[0];
               end
               for (int i = 0; i < PRESCALE_W; i++) begin
                  if (wmask[16+i]) begin
                     div_d[i] = bus_write_data[16+i];
                  end
               end
            end
            default: begin
            end
         endcase
      end

      irq_d = (mtime_d >= mtimecmp_d);
   end

`ifdef MACHINE_TIMER_SNAPSHOT_EN
   always_comb begin
      shadow_d = shadow_q;
      if (rd_hit && (offset == OFF_MTIME_LO)) begin
         shadow_d = mtime_q[63:32];
      end
   end
`endif

   always_comb begin
      bus_read_data = '0;
      if (rd_hit) begin
         case (offset)
            OFF_MTIME_LO: bus_read_data = mtime_q[31:0];
`ifdef MACHINE_TIMER_SNAPSHOT_EN
            OFF_MTIME_HI: bus_read_data = shadow_q;
`else
            OFF_MTIME_HI: bus_read_data = mtime_q[63:32];
`endif
            OFF_CMP_LO:   bus_read_data = mtimecmp_q[31:0];
            OFF_CMP_HI:   bus_read_data = mtimecmp_q[63:32];
            OFF_CTRL:     bus_read_data = ctrl_word;
            default:      bus_read_data = '0;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mtime_q    <= '0;
         mtimecmp_q <= '1;
         enable_q   <= 1'b0;
         div_q      <= '0;
         pcnt_q     <= '0;
         irq_q      <= 1'b0;
`ifdef MACHINE_TIMER_SNAPSHOT_EN
         shadow_q   <= '0;
`endif
      end else begin
         mtime_q    <= mtime_d;
         mtimecmp_q <= mtimecmp_d;
         enable_q   <= enable_d;
         div_q      <= div_d;
         pcnt_q     <= pcnt_d;
         irq_q      <= irq_d;
`ifdef MACHINE_TIMER_SNAPSHOT_EN
         shadow_q   <= shadow_d;
`endif
      end
   end

   assign bus_busy                = 1'b0;
   assign timer_interrupt_request = irq_q;

endmodule
`default_nettype wire
